// File: rtl/enc_pkg.sv
// ============================================================================
//  Module      : enc_pkg
//  Description : Shared constants and types for the encoder input conditioner.
//                Holds the default debounce interval, the idle level of the
//                active-low pushbutton, and the quadrature state encodings
//                used by the optional x4 decoder.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package enc_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 50000;
  localparam int unsigned CNT_W_DEFAULT           = 16;

  // The pushbutton is active-low, so its released (idle) level is 1.
  localparam logic PB_IDLE = 1'b1;
  // Encoder phases idle low.
  localparam logic AB_IDLE = 1'b0;

  // Quadrature state, encoded as {A,B}. Clockwise order is
  // 00 -> 10 -> 11 -> 01 -> 00 (A leading B).
  typedef enum logic [1:0] {
    QS_00 = 2'b00,
    QS_10 = 2'b10,
    QS_11 = 2'b11,
    QS_01 = 2'b01
  } quad_state_e;

  localparam quad_state_e QUAD_RESET_STATE = QS_00;

  // Next state one clockwise step after s.
  function automatic quad_state_e quad_cw_next(input quad_state_e s);
    quad_state_e n;
    case (s)
      QS_00:   n = QS_10;
      QS_10:   n = QS_11;
      QS_11:   n = QS_01;
      default: n = QS_00;
    endcase
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/encoder_input_conditioner_if.sv
// ============================================================================
//  Module      : encoder_input_conditioner_if
//  Description : Signal bundle between the raw encoder/pushbutton pins and the
//                downstream counter stage.
//                master : drives A_raw, B_raw, PB_raw; observes conditioned
//                         outputs.
//                slave  : the conditioner itself; samples the raw pins and
//                         drives A, B, PB, pb_press, pb_release, step_cw,
//                         step_ccw, quad_err.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface encoder_input_conditioner_if;

  logic A_raw;
  logic B_raw;
  logic PB_raw;

  logic A;
  logic B;
  logic PB;
  logic pb_press;
  logic pb_release;
  logic step_cw;
  logic step_ccw;
  logic quad_err;

  modport master (
    output A_raw, B_raw, PB_raw,
    input  A, B, PB, pb_press, pb_release, step_cw, step_ccw, quad_err
  );

  modport slave (
    input  A_raw, B_raw, PB_raw,
    output A, B, PB, pb_press, pb_release, step_cw, step_ccw, quad_err
  );

endinterface

`default_nettype wire

// File: rtl/debounce_channel.sv
// ============================================================================
//  Module      : debounce_channel
//  Description : One conditioned input: 2-flop synchronizer followed by a
//                stability counter. The debounced level only moves after the
//                synchronized value has disagreed with it for DEBOUNCE_CYCLES
//                consecutive cycles.
//  Ports       : clk      - rising-edge clock
//                reset    - asynchronous, active-high reset
//                raw_i    - raw asynchronous input
//                level_o  - synchronized, debounced level
//  Parameters  : RESET_LEVEL, DEBOUNCE_CYCLES (1..65535), CNT_W
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module debounce_channel
  import enc_pkg::*;
#(
  parameter logic        RESET_LEVEL     = 1'b0,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The counter holds the number of consecutive disagreeing cycles already
  // seen; on the DEBOUNCE_CYCLES-th one the level is accepted instead of
  // counting further, so the counter tops out at DEBOUNCE_CYCLES-1.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= RESET_LEVEL;
      sync2_q <= RESET_LEVEL;
      level_q <= RESET_LEVEL;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

`default_nettype wire

// File: rtl/encoder_input_conditioner.sv
// ============================================================================
//  Module      : encoder_input_conditioner
//  Description : Conditions the raw A/B encoder phases and the active-low
//                pushbutton: synchronize, debounce, and derive single-cycle
//                press/release pulses. Optionally decodes x4 quadrature steps.
//  Ports       : clk    - rising-edge clock
//                reset  - asynchronous, active-high reset
//                enc    - encoder_input_conditioner_if.slave
//                         in : A_raw, B_raw, PB_raw
//                         out: A, B, PB, pb_press, pb_release,
//                              step_cw, step_ccw, quad_err
//  Parameters  : DEBOUNCE_CYCLES (1..65535), CNT_W
//  Build macro : ENC_COND_QUAD_DECODE_EN - when defined, compiles in the
//                quadrature decoder; otherwise step_cw/step_ccw/quad_err are
//                tied low and no decoder flops exist.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module encoder_input_conditioner
  import enc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
  input  logic                              clk,
  input  logic                              reset,
  encoder_input_conditioner_if.slave        enc
);

  logic a_lvl;
  logic b_lvl;
  logic pb_lvl;
  logic pb_prev_q;

  debounce_channel #(
    .RESET_LEVEL     (AB_IDLE),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_deb_a (
    .clk     (clk),
    .reset   (reset),
    .raw_i   (enc.A_raw),
    .level_o (a_lvl)
  );

  debounce_channel #(
    .RESET_LEVEL     (AB_IDLE),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_deb_b (
    .clk     (clk),
    .reset   (reset),
    .raw_i   (enc.B_raw),
    .level_o (b_lvl)
  );

  debounce_channel #(
    .RESET_LEVEL     (PB_IDLE),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_deb_pb (
    .clk     (clk),
    .reset   (reset),
    .raw_i   (enc.PB_raw),
    .level_o (pb_lvl)
  );

  assign enc.A  = a_lvl;
  assign enc.B  = b_lvl;
  assign enc.PB = pb_lvl;

  // Previous debounced PB level. Both operands are flop outputs, so the
  // pulses are clean and coincide with the first cycle of the new level.
  // Resetting to the idle level keeps the reset release pulse-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pb_prev_q <= PB_IDLE;
    end else begin
      pb_prev_q <= pb_lvl;
    end
  end

  assign enc.pb_press   =  pb_prev_q & ~pb_lvl;
  assign enc.pb_release = ~pb_prev_q &  pb_lvl;

`ifdef ENC_COND_QUAD_DECODE_EN
  quad_state_e ab_cur;
  quad_state_e prev_q;
  logic        cw_d;
  logic        ccw_d;
  logic        err_d;
  logic        cw_q;
  logic        ccw_q;
  logic        err_q;

  assign ab_cur = quad_state_e'({a_lvl, b_lvl});

  // A double-bit change skips a state and cannot be attributed to a
  // direction, so it is flagged as an error and counted as neither step.
  always_comb begin
    cw_d  = (ab_cur == quad_cw_next(prev_q));
    ccw_d = (prev_q == quad_cw_next(ab_cur));
    err_d = ((prev_q ^ ab_cur) == 2'b11);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= QUAD_RESET_STATE;
      cw_q   <= 1'b0;
      ccw_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      prev_q <= ab_cur;
      cw_q   <= cw_d;
      ccw_q  <= ccw_d;
      err_q  <= err_d;
    end
  end

  assign enc.step_cw  = cw_q;
  assign enc.step_ccw = ccw_q;
  assign enc.quad_err = err_q;
`else
  assign enc.step_cw  = 1'b0;
  assign enc.step_ccw = 1'b0;
  assign enc.quad_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_encoder_input_conditioner.sv
// ============================================================================
//  Module      : tb_encoder_input_conditioner
//  Description : Self-checking bench for encoder_input_conditioner with
//                DEBOUNCE_CYCLES=4. A reference model expresses the debounce
//                rule directly: the level flips once the last DEBOUNCE_CYCLES
//                synchronized samples all disagree with it.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_encoder_input_conditioner;

  localparam int DC = 4;
`ifdef ENC_COND_QUAD_DECODE_EN
  localparam bit QUAD_ON = 1'b1;
`else
  localparam bit QUAD_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  encoder_input_conditioner_if ifc ();

  encoder_input_conditioner #(
    .DEBOUNCE_CYCLES (DC),
    .CNT_W           (16)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .enc   (ifc)
  );

  // ---------------- reference model ----------------
  bit       hist [3][$];   // raw samples per channel, oldest first
  bit [2:0] m_lvl;         // [0]=A [1]=B [2]=PB
  bit       m_press, m_release, m_cw, m_ccw, m_err;
  bit [1:0] m_ab_old;

  function automatic bit quad_fwd(input bit [1:0] from, input bit [1:0] to);
    bit [1:0] seq [4];
    seq = '{2'b00, 2'b10, 2'b11, 2'b01};
    for (int i = 0; i < 4; i++)
      if (seq[i] == from) return (seq[(i + 1) % 4] == to);
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < 3; ch++) begin
      hist[ch].delete();
      repeat (DC + 1) hist[ch].push_back(ch == 2);
    end
    m_lvl     = 3'b100;
    m_press   = 1'b0;
    m_release = 1'b0;
    m_cw      = 1'b0;
    m_ccw     = 1'b0;
    m_err     = 1'b0;
    m_ab_old  = 2'b00;
  endtask

  task automatic model_edge();
    bit       raw [3];
    bit [1:0] ab_before;
    bit       pb_before;
    bit       all_opp;
    if (rst) begin
      model_reset();
      return;
    end
    raw[0]    = ifc.A_raw;
    raw[1]    = ifc.B_raw;
    raw[2]    = ifc.PB_raw;
    ab_before = {m_lvl[0], m_lvl[1]};
    pb_before = m_lvl[2];
    for (int ch = 0; ch < 3; ch++) begin
      hist[ch].push_back(raw[ch]);
      while (hist[ch].size() > DC + 2) void'(hist[ch].pop_front());
      // The newest two samples are still inside the synchronizer.
      all_opp = 1'b1;
      for (int i = 0; i < DC; i++)
        if (hist[ch][i] == m_lvl[ch]) all_opp = 1'b0;
      if (all_opp) m_lvl[ch] = ~m_lvl[ch];
    end
    m_press   =  pb_before && !m_lvl[2];
    m_release = !pb_before &&  m_lvl[2];
    m_cw      = QUAD_ON && quad_fwd(m_ab_old, ab_before);
    m_ccw     = QUAD_ON && quad_fwd(ab_before, m_ab_old);
    m_err     = QUAD_ON && ((m_ab_old ^ ab_before) == 2'b11);
    m_ab_old  = ab_before;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic hold_count(input int n, output int cw, output int ccw, output int err);
    cw = 0; ccw = 0; err = 0;
    repeat (n) begin
      tick();
      if (ifc.step_cw  === 1'b1) cw++;
      if (ifc.step_ccw === 1'b1) ccw++;
      if (ifc.quad_err === 1'b1) err++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int seen;
    #2;
    rst = 1'b1;
    ifc.A_raw = 1'b1; ifc.B_raw = 1'b1; ifc.PB_raw = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({ifc.A, ifc.B, ifc.PB} !== 3'b001)
      $display("FAIL reset_levels_async: got %b required 001", {ifc.A, ifc.B, ifc.PB});
    repeat (3) tick();
    checks++;
    if ({ifc.A, ifc.B, ifc.PB} !== 3'b001)
      $display("FAIL reset_levels_held: got %b required 001", {ifc.A, ifc.B, ifc.PB});
    if ({ifc.A, ifc.B, ifc.PB} !== 3'b001) errors++;
    checks++;
    if ({ifc.pb_press, ifc.pb_release, ifc.step_cw, ifc.step_ccw, ifc.quad_err} !== 5'b0) begin
      $display("FAIL reset_pulses: got %b required 00000",
               {ifc.pb_press, ifc.pb_release, ifc.step_cw, ifc.step_ccw, ifc.quad_err});
      errors++;
    end
    ifc.A_raw = 1'b0; ifc.B_raw = 1'b0; ifc.PB_raw = 1'b1;
    tick();
    rst = 1'b0;
    seen = 0;
    repeat (10) begin
      tick();
      if ((ifc.pb_press | ifc.pb_release | ifc.step_cw | ifc.step_ccw | ifc.quad_err) !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin
      $display("FAIL reset_release_pulses: got %0d pulse cycles required 0", seen);
      errors++;
    end
  endtask

  task automatic test_pb_press();
    int n, presses, releases;
    bit pulse_now;
    ifc.PB_raw = 1'b0;
    n = 0; presses = 0; releases = 0; pulse_now = 1'b0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      tick();
      if (ifc.pb_release === 1'b1) releases++;
      if (ifc.PB === 1'b0) begin n = i; pulse_now = ifc.pb_press; end
      else if (ifc.pb_press === 1'b1) presses++;
    end
    checks++;
    if (n !== DC + 2) begin
      $display("FAIL pb_press_latency: got %0d cycles required %0d", n, DC + 2); errors++;
    end
    checks++;
    if (pulse_now !== 1'b1 || presses !== 0) begin
      $display("FAIL pb_press_pulse: at_fall=%b early=%0d required 1/0", pulse_now, presses); errors++;
    end
    tick();
    checks++;
    if (ifc.pb_press !== 1'b0 || releases !== 0) begin
      $display("FAIL pb_press_width: press=%b releases=%0d required 0/0", ifc.pb_press, releases); errors++;
    end
    ifc.PB_raw = 1'b1;
    n = 0; pulse_now = 1'b0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      tick();
      if (ifc.PB === 1'b1) begin n = i; pulse_now = ifc.pb_release & ~ifc.pb_press; end
    end
    checks++;
    if (n !== DC + 2 || pulse_now !== 1'b1) begin
      $display("FAIL pb_release: latency=%0d pulse=%b required %0d/1", n, pulse_now, DC + 2); errors++;
    end
    repeat (3) tick();
  endtask

  task automatic test_glitch();
    int a_seen, cw_seen;
    a_seen = 0; cw_seen = 0;
    ifc.A_raw = 1'b1;
    repeat (DC - 1) tick();
    ifc.A_raw = 1'b0;
    repeat (12) begin
      tick();
      if (ifc.A === 1'b1) a_seen++;
      if (ifc.step_cw === 1'b1) cw_seen++;
    end
    checks++;
    if (a_seen !== 0 || cw_seen !== 0) begin
      $display("FAIL glitch_rejected: A_high=%0d cw=%0d required 0/0", a_seen, cw_seen); errors++;
    end
    a_seen = 0;
    ifc.A_raw = 1'b1;
    repeat (DC) tick();
    ifc.A_raw = 1'b0;
    repeat (14) begin
      tick();
      if (ifc.A === 1'b1) a_seen++;
    end
    checks++;
    if (a_seen !== DC) begin
      $display("FAIL glitch_boundary_accept: A_high=%0d cycles required %0d", a_seen, DC); errors++;
    end
  endtask

  task automatic test_quad_steps();
    int cw, ccw, err, tcw, tccw, terr;
    bit [1:0] fwd [4];
    fwd = '{2'b10, 2'b11, 2'b01, 2'b00};
    tcw = 0; tccw = 0; terr = 0;
    for (int i = 0; i < 4; i++) begin
      {ifc.A_raw, ifc.B_raw} = fwd[i];
      hold_count(10, cw, ccw, err);
      tcw += cw; tccw += ccw; terr += err;
    end
    checks++;
    if (tcw !== (QUAD_ON ? 4 : 0) || tccw !== 0 || terr !== 0) begin
      $display("FAIL quad_cw_seq: cw=%0d ccw=%0d err=%0d required %0d/0/0",
               tcw, tccw, terr, QUAD_ON ? 4 : 0); errors++;
    end
    tcw = 0; tccw = 0; terr = 0;
    for (int i = 0; i < 4; i++) begin
      {ifc.A_raw, ifc.B_raw} = fwd[(6 - i) % 4];
      hold_count(10, cw, ccw, err);
      tcw += cw; tccw += ccw; terr += err;
    end
    checks++;
    if (tcw !== 0 || tccw !== (QUAD_ON ? 4 : 0) || terr !== 0) begin
      $display("FAIL quad_ccw_seq: cw=%0d ccw=%0d err=%0d required 0/%0d/0",
               tcw, tccw, terr, QUAD_ON ? 4 : 0); errors++;
    end
  endtask

  task automatic test_quad_err();
    int cw, ccw, err;
    {ifc.A_raw, ifc.B_raw} = 2'b11;
    hold_count(12, cw, ccw, err);
    checks++;
    if (cw !== 0 || ccw !== 0 || err !== (QUAD_ON ? 1 : 0)) begin
      $display("FAIL quad_err_00_11: cw=%0d ccw=%0d err=%0d required 0/0/%0d",
               cw, ccw, err, QUAD_ON ? 1 : 0); errors++;
    end
    {ifc.A_raw, ifc.B_raw} = 2'b00;
    hold_count(12, cw, ccw, err);
    checks++;
    if (cw !== 0 || ccw !== 0 || err !== (QUAD_ON ? 1 : 0)) begin
      $display("FAIL quad_err_11_00: cw=%0d ccw=%0d err=%0d required 0/0/%0d",
               cw, ccw, err, QUAD_ON ? 1 : 0); errors++;
    end
  endtask

  task automatic test_reset_mid_debounce();
    int n, bad;
    bit pulse_now;
    ifc.PB_raw = 1'b0;
    repeat (DC) tick();
    rst = 1'b1;
    model_reset();
    bad = 0;
    repeat (2) begin
      tick();
      if (ifc.PB !== 1'b1 || ifc.pb_press !== 1'b0) bad++;
    end
    rst = 1'b0;
    checks++;
    if (bad !== 0) begin
      $display("FAIL reset_mid_discard: bad cycles=%0d required 0", bad); errors++;
    end
    n = 0; pulse_now = 1'b0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      tick();
      if (ifc.PB === 1'b0) begin n = i; pulse_now = ifc.pb_press; end
    end
    checks++;
    if (n !== DC + 2 || pulse_now !== 1'b1) begin
      $display("FAIL reset_mid_full_interval: latency=%0d press=%b required %0d/1",
               n, pulse_now, DC + 2); errors++;
    end
    ifc.PB_raw = 1'b1;
    repeat (DC + 6) tick();
  endtask

  task automatic test_random();
    int       hold [3];
    bit       nv;
    logic [7:0] obs, expv;
    int       bad;
    hold = '{0, 0, 0};
    bad  = 0;
    for (int i = 0; i < 400; i++) begin
      for (int ch = 0; ch < 3; ch++) begin
        if (hold[ch] == 0) begin
          nv       = 1'($urandom_range(0, 1));
          hold[ch] = int'($urandom_range(1, 2 * DC + 2));
          case (ch)
            0:       ifc.A_raw  = nv;
            1:       ifc.B_raw  = nv;
            default: ifc.PB_raw = nv;
          endcase
        end
        hold[ch]--;
      end
      if (i == 200) begin
        rst = 1'b1;
        model_reset();
      end
      if (i == 203) rst = 1'b0;
      tick();
      obs  = {ifc.A, ifc.B, ifc.PB, ifc.pb_press, ifc.pb_release,
              ifc.step_cw, ifc.step_ccw, ifc.quad_err};
      expv = {m_lvl[0], m_lvl[1], m_lvl[2], m_press, m_release, m_cw, m_ccw, m_err};
      checks++;
      if (obs !== expv) begin
        errors++;
        if (bad < 10)
          $display("FAIL random_cycle_%0d: got A,B,PB,prs,rel,cw,ccw,err=%b required %b", i, obs, expv);
        bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_pb_press();
    test_glitch();
    test_quad_steps();
    test_quad_err();
    test_reset_mid_debounce();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/encoder_input_conditioner.md
ENCODER_INPUT_CONDITIONER -- requirements
Module: encoder_input_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000, stable cycles required before an input change is accepted (legal range 1..65535).
REQ-002 SHALL have parameter CNT_W, default 16, debounce counter width; DEBOUNCE_CYCLES SHALL fit in CNT_W bits.
REQ-003 SHALL have port clk  input  1  sole clock, all flops rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports A_raw, B_raw  input  1 each  raw encoder phases, asynchronous to clk.
REQ-006 SHALL have port PB_raw  input  1  raw pushbutton, active-low, asynchronous to clk.
REQ-007 SHALL have ports A, B, PB  output  1 each  synchronized, debounced levels for the downstream encoder counter stage.
REQ-008 SHALL have ports pb_press, pb_release  output  1 each  single-cycle pulses on debounced PB falling/rising edge.
REQ-009 SHALL have ports step_cw, step_ccw, quad_err  output  1 each  single-cycle quadrature pulses (see Configuration).

Function
REQ-010 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-011 Per channel, a counter SHALL increment each cycle the synchronized value differs from the debounced output, and clear to 0 on any cycle they agree.
REQ-012 When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced output SHALL take the synchronized value on the next edge and the counter SHALL clear.
REQ-013 Latency from a clean raw change to the debounced output change SHALL be exactly 2 + DEBOUNCE_CYCLES cycles.
REQ-014 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no output change and no pulses.
REQ-015 With DEBOUNCE_CYCLES=1, the debounced output SHALL follow the synchronized value with one cycle of delay.
REQ-016 Counters SHALL never wrap; they clear upon acceptance and never exceed DEBOUNCE_CYCLES-1.
REQ-017 pb_press SHALL be high for exactly the one cycle after PB transitions 1->0; pb_release likewise for 0->1; never both in the same cycle.
REQ-018 Channels SHALL be independent; simultaneous A and B acceptance in one cycle SHALL be legal at this level.

Reset
REQ-019 While reset is high: synchronizer flops and A, B SHALL be 0; PB and its synchronizer flops SHALL be 1; all counters 0; all pulse outputs 0.
REQ-020 Reset assertion mid-debounce SHALL discard the pending change; after deassertion the first pulse SHALL require a full REQ-013 interval.
REQ-021 No pulse SHALL be generated by the reset-to-run transition itself.

Configuration
REQ-022 Macro ENC_COND_QUAD_DECODE_EN SHALL, when defined, compile in an x4 quadrature decoder on the debounced {A,B}, with previous state held in a register reset to 2'b00.
REQ-023 With the macro defined: sequence 00->10->11->01->00 (A leading) SHALL pulse step_cw once per transition; the reverse order SHALL pulse step_ccw; a transition in which both bits change SHALL pulse quad_err and neither step.
REQ-024 Without the macro: step_cw, step_ccw, quad_err SHALL be tied 0 and no decoder flops SHALL exist.

Structure
REQ-025 A shared package enc_pkg SHALL hold the default DEBOUNCE_CYCLES, PB idle level (1), and quadrature state encodings.
REQ-026 A sub-module debounce_channel (synchronizer + counter + debounced output, parameterised by reset level) SHALL be instantiated three times.
REQ-027 The block SHALL be 120-400 lines of RTL total.

Verification
REQ-028 DEBOUNCE_CYCLES=4: PB_raw 1->0 held -> PB falls exactly 6 cycles later; pb_press high 1 cycle.
REQ-029 DEBOUNCE_CYCLES=4: A_raw pulses high for 3 cycles -> A stays 0, no step_cw.
REQ-030 Macro defined, DEBOUNCE_CYCLES=2: drive 00->10->11->01->00 with 10-cycle holds -> 4 step_cw pulses, 0 step_ccw, 0 quad_err.
REQ-031 Macro defined: A_raw and B_raw flip together 00->11 -> one quad_err pulse, no steps.
REQ-032 reset asserted 2 cycles before a pending PB acceptance -> PB remains 1, no pb_press; after release a full 2+DEBOUNCE_CYCLES interval is required.
REQ-033 Macro undefined: any A/B stimulus -> step_cw, step_ccw, quad_err constantly 0.
